tuser_out_sched: RTL



---
 rtl/tuser_out_sched_if.sv | 28 ++
 rtl/tuser_out_sched.sv | 98 +++++++++
 2 files changed

// File: rtl/tuser_out_sched_if.sv
// Stream bundle used on both sides of the tuple scheduler.
// atuser is only meaningful on the output side.
interface tuser_out_sched_if #(
  parameter int DATA_W  = 256,
  parameter int TUPLE_W = 128
);
  logic               avalid;
  logic               aready;
  logic               alast;
  logic [DATA_W-1:0]  adata;
  logic [TUPLE_W-1:0] atuser;

  modport master (
    output avalid,
    input  aready,
    output alast,
    output adata,
    output atuser
  );

  modport slave (
    input  avalid,
    output aready,
    input  alast,
    input  adata,
    input  atuser
  );
endinterface

// File: rtl/tuser_out_sched.sv
// Attaches one queued SDNet tuple to each outgoing packet as tuser.
// Tuples that arrive early wait in a small FIFO; SOP stalls until one exists.
module tuser_out_sched #(
  parameter int DATA_W  = 256,
  parameter int TUPLE_W = 128,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic               tsch_aclk,
  input  logic               tsch_arst,
  input  logic               tsch_tvalid,
  input  logic [TUPLE_W-1:0] tsch_tdata,
  tuser_out_sched_if.slave   s,
  tuser_out_sched_if.master  m,
  output logic [LW-1:0]      tsch_level,
  output logic               tsch_stall,
  output logic               tsch_ovf,
  output logic [CNT_W-1:0]   tsch_drop_cnt
);

  typedef enum logic {
    IDLE,
    PKT
  } state_t;

  state_t             state;
  logic [TUPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [TUPLE_W-1:0] cur_tuple;

  logic empty;
  logic full;
  logic tup_ok;
  logic beat;
  logic pop;
  logic push;
  logic drop;

  assign empty  = (tsch_level == '0);
  assign full   = (tsch_level == LW'(DEPTH));
  assign tup_ok = (state == PKT) | ~empty;
  assign beat   = s.avalid & m.aready & tup_ok;
  assign pop    = beat & (state == IDLE);
  // a pop in the same cycle frees the slot the push needs
  assign push   = tsch_tvalid & (~full | pop);
  assign drop   = tsch_tvalid & full & ~pop;

  assign m.avalid = s.avalid & tup_ok;
  assign s.aready = m.aready & tup_ok;
  assign m.alast  = s.alast;
  assign m.adata  = s.adata;
  assign m.atuser = (state == IDLE) ? mem[rd_ptr] : cur_tuple;

  assign tsch_stall = (state == IDLE) & s.avalid & empty;

  always_ff @(posedge tsch_aclk) begin
    if (push) mem[wr_ptr] <= tsch_tdata;
  end

  always_ff @(posedge tsch_aclk or negedge tsch_arst) begin
    if (!tsch_arst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tsch_level    <= '0;
      cur_tuple     <= '0;
      tsch_ovf      <= 1'b0;
      tsch_drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        cur_tuple <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   tsch_level <= tsch_level + 1'b1;
        2'b01:   tsch_level <= tsch_level - 1'b1;
        default: tsch_level <= tsch_level;
      endcase
      if (drop) begin
        tsch_ovf <= 1'b1;
        if (tsch_drop_cnt != '1)
          tsch_drop_cnt <= tsch_drop_cnt + 1'b1;
      end
      if (beat) begin
        unique case (state)
          IDLE:    if (!s.alast) state <= PKT;
          PKT:     if (s.alast) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
